// File: rtl/useq_pkg.sv
// Shared definitions for the stacked microsequencer.
//   - LC-3 compatible COND codes (COND_NONE .. COND_INT)
//   - seq_act_e: the single action the sequencer takes in a cycle
//   - qual_pos(): extracts the J bit position of qualifier k from the packed
//     4-bit-per-field position vector
//   - clog2(): ceiling log2 used to size occupancy counters
package useq_pkg;

  localparam logic [2:0] COND_NONE = 3'd0;
  localparam logic [2:0] COND_RDY  = 3'd1;
  localparam logic [2:0] COND_BEN  = 3'd2;
  localparam logic [2:0] COND_IR11 = 3'd3;
  localparam logic [2:0] COND_PRIV = 3'd4;
  localparam logic [2:0] COND_INT  = 3'd5;

  // One action per cycle, already resolved by priority (stall > return > call).
  typedef enum logic [2:0] {
    ACT_HOLD = 3'd0,
    ACT_POP  = 3'd1,
    ACT_UNF  = 3'd2,
    ACT_PUSH = 3'd3,
    ACT_OVF  = 3'd4,
    ACT_JUMP = 3'd5
  } seq_act_e;

  // Field k of the packed position vector names the J bit qualifier k ORs into.
  function automatic logic [3:0] qual_pos(input logic [63:0] pos_vec, input int k);
    return pos_vec[4*k +: 4];
  endfunction

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/useq_lifo.sv
// Return-address LIFO for the microsequencer.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears occupancy only)
//   push_i, pop_i     push data_i / drop the top entry (never both at once)
//   data_i            value to push
//   top_o             most recently pushed entry (don't-care when empty)
//   depth_o           number of valid entries (registered)
//   full_o, empty_o   occupancy flags
module useq_lifo
  import useq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [W-1:0]                data_i,
  output logic [W-1:0]                top_o,
  output logic [clog2(DEPTH+1)-1:0]   depth_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int DW = clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_d;

  // Occupancy next-state: push grows, pop shrinks, parent never issues both.
  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o) begin
      depth_d = depth_q + DW'(1);
    end else if (pop_i && !empty_o) begin
      depth_d = depth_q - DW'(1);
    end else begin
      depth_d = depth_q;
    end
  end

  // Occupancy register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= DW'(0);
    end else begin
      depth_q <= depth_d;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && push_i && (depth_q == DW'(i))) begin
        mem_q[i] <= data_i;
      end
    end
  end

  // Top-of-stack read: entry just below the occupancy pointer.
  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) begin
        top_o = mem_q[i];
      end else begin
        top_o = top_o;
      end
    end
  end

  assign depth_o = depth_q;
  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == DW'(0));

endmodule

// File: rtl/useq_stack_seq.sv
// Microsequencer with LC-3 compatible next-address logic plus a hardware
// return stack for microsubroutines.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   ird          dispatch on opcode (target = opcode + DISPATCH_BASE)
//   cond         qualifier select, 0 / out of range = unconditional
//   j            base next address
//   qual         qualifier inputs
//   opcode       IR opcode field
//   ucall        push uaddr+1 and jump to the computed target
//   uret         pop and jump to the popped address
//   stall        freeze all state
//   uaddr        current microaddress (registered)
//   depth        return-stack occupancy
//   ovf, unf     sticky stack overflow / underflow, cleared only by rst
module useq_stack_seq
  import useq_pkg::*;
#(
  parameter int                      ADDR_W        = 6,
  parameter int                      COND_W        = 3,
  parameter int                      NUM_QUAL      = 5,
  parameter logic [4*NUM_QUAL-1:0]   QUAL_POS      = 20'h43021,
  parameter int                      OPC_W         = 4,
  parameter int                      DISPATCH_BASE = 0,
  parameter int                      STACK_DEPTH   = 4,
  parameter int                      RESET_ADDR    = 18
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ird,
  input  logic [COND_W-1:0]                 cond,
  input  logic [ADDR_W-1:0]                 j,
  input  logic [NUM_QUAL-1:0]               qual,
  input  logic [OPC_W-1:0]                  opcode,
  input  logic                              ucall,
  input  logic                              uret,
  input  logic                              stall,
  output logic [ADDR_W-1:0]                 uaddr,
  output logic [clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                              ovf,
  output logic                              unf
);

  logic [ADDR_W-1:0] uaddr_q, uaddr_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [ADDR_W-1:0] branch_s;
  logic [ADDR_W-1:0] disp_s;
  logic [ADDR_W-1:0] tgt_s;
  logic [ADDR_W-1:0] top_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  seq_act_e          act_s;

  // Conditional branch: the selected qualifier ORs into its assigned J bit.
  always_comb begin
    branch_s = j;
    for (int k = 0; k < NUM_QUAL; k++) begin
      if (int'(cond) == k + 1) begin
        branch_s = j | (ADDR_W'(qual[k]) << qual_pos(64'(QUAL_POS), k));
      end else begin
        branch_s = branch_s;
      end
    end
  end

  // Opcode dispatch; the sum wraps to the address width.
  assign disp_s = ADDR_W'(opcode) + ADDR_W'(DISPATCH_BASE);
  assign tgt_s  = ird ? disp_s : branch_s;

  // Resolve the cycle's action by priority: stall, return, call, plain jump.
  always_comb begin
    act_s = ACT_JUMP;
    if (stall) begin
      act_s = ACT_HOLD;
    end else if (uret) begin
      act_s = empty_s ? ACT_UNF : ACT_POP;
    end else if (ucall) begin
      act_s = full_s ? ACT_OVF : ACT_PUSH;
    end else begin
      act_s = ACT_JUMP;
    end
  end

  // Next-state values and stack controls for the chosen action.
  always_comb begin
    uaddr_d = uaddr_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    case (act_s)
      ACT_HOLD: begin
        uaddr_d = uaddr_q;
      end
      ACT_POP: begin
        uaddr_d = top_s;
        pop_s   = 1'b1;
      end
      ACT_UNF: begin
        uaddr_d = ADDR_W'(RESET_ADDR);
        unf_d   = 1'b1;
      end
      ACT_PUSH: begin
        uaddr_d = tgt_s;
        push_s  = 1'b1;
      end
      ACT_OVF: begin
        uaddr_d = tgt_s;
        ovf_d   = 1'b1;
      end
      ACT_JUMP: begin
        uaddr_d = tgt_s;
      end
      default: begin
        uaddr_d = uaddr_q;
      end
    endcase
  end

  // Microaddress and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      uaddr_q <= ADDR_W'(RESET_ADDR);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      uaddr_q <= uaddr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return address is the following microinstruction, wrapping at the top.
  useq_lifo #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (uaddr_q + ADDR_W'(1)),
    .top_o   (top_s),
    .depth_o (depth),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign uaddr = uaddr_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_useq_stack_seq.sv
module tb_useq_stack_seq;

  logic       clk = 1'b0;
  logic       rst, ird, ucall, uret, stall;
  logic [2:0] cond;
  logic [5:0] j;
  logic [4:0] qual;
  logic [3:0] opcode;

  logic [5:0] u0, u1;
  logic [2:0] d0;
  logic [1:0] d1;
  logic       o0, o1, n0, n1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut0: default parameters; dut1: shifted dispatch and a shallow stack.
  useq_stack_seq dut0 (
    .clk(clk), .rst(rst), .ird(ird), .cond(cond), .j(j), .qual(qual),
    .opcode(opcode), .ucall(ucall), .uret(uret), .stall(stall),
    .uaddr(u0), .depth(d0), .ovf(o0), .unf(n0)
  );

  useq_stack_seq #(.DISPATCH_BASE(60), .STACK_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .ird(ird), .cond(cond), .j(j), .qual(qual),
    .opcode(opcode), .ucall(ucall), .uret(uret), .stall(stall),
    .uaddr(u1), .depth(d1), .ovf(o1), .unf(n1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  int qpos [5] = '{1, 2, 0, 3, 4};   // rdy, ben, ir11, priv, int
  int maxd [2] = '{4, 2};
  int base [2] = '{0, 60};
  int m_ua [2];
  int m_dep[2];
  int m_ovf[2];
  int m_unf[2];
  int m_stk[2][8];
  bit started = 1'b0;

  function automatic int model_tgt(input int b);
    int c;
    c = int'(cond);
    if (ird) return (int'(opcode) + b) % 64;
    if (c >= 1 && c <= 5 && qual[c-1]) return int'(j) | (1 << qpos[c-1]);
    return int'(j);
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int t;
      t = model_tgt(base[m]);
      if (rst) begin
        m_ua[m] = 18; m_dep[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
      end else if (stall) begin
        // everything holds
      end else if (uret) begin
        if (m_dep[m] > 0) begin
          m_dep[m] = m_dep[m] - 1;
          m_ua[m]  = m_stk[m][m_dep[m]];
        end else begin
          m_ua[m]  = 18;
          m_unf[m] = 1;
        end
      end else if (ucall) begin
        if (m_dep[m] < maxd[m]) begin
          m_stk[m][m_dep[m]] = (m_ua[m] + 1) % 64;
          m_dep[m] = m_dep[m] + 1;
        end else begin
          m_ovf[m] = 1;
        end
        m_ua[m] = t;
      end else begin
        m_ua[m] = t;
      end
    end
    if (rst) started = 1'b1;
    #1;
    if (started) begin
      chk("uaddr0", int'(u0), m_ua[0]);
      chk("depth0", int'(d0), m_dep[0]);
      chk("ovf0",   int'(o0), m_ovf[0]);
      chk("unf0",   int'(n0), m_unf[0]);
      chk("uaddr1", int'(u1), m_ua[1]);
      chk("depth1", int'(d1), m_dep[1]);
      chk("ovf1",   int'(o1), m_ovf[1]);
      chk("unf1",   int'(n1), m_unf[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ird = 1'b0; ucall = 1'b0; uret = 1'b0; stall = 1'b0;
    cond = 3'd0; j = 6'd0; qual = 5'd0; opcode = 4'd0;

    cyc();
    chk("rst_uaddr", int'(u0), 18); chk("rst_depth", int'(d0), 0);
    chk("rst_ovf", int'(o0), 0);    chk("rst_unf", int'(n0), 0);
    stall = 1'b1; ucall = 1'b1;
    cyc();
    chk("rst_over_stall", int'(u0), 18); chk("rst_over_call", int'(d0), 0);

    rst = 1'b0; stall = 1'b0; ucall = 1'b0;
    j = 6'd32; cond = 3'd1; qual = 5'b00001;
    cyc(); chk("rdy_set", int'(u0), 34);
    qual = 5'b00000;
    cyc(); chk("rdy_clr", int'(u0), 32);
    cond = 3'd3; qual = 5'b00100;
    cyc(); chk("ir11_set", int'(u0), 33);
    cond = 3'd0; ird = 1'b1; opcode = 4'hB;
    cyc(); chk("disp_b0", int'(u0), 11); chk("disp_b60", int'(u1), 7);

    ird = 1'b0; j = 6'd20;
    cyc(); chk("jump20", int'(u0), 20);
    ucall = 1'b1; j = 6'd40;
    cyc(); chk("call_tgt", int'(u0), 40); chk("call_depth", int'(d0), 1);
    ucall = 1'b0; uret = 1'b1;
    cyc(); chk("ret_addr", int'(u0), 21); chk("ret_depth", int'(d0), 0);

    // nested calls past the shallow stack of dut1
    uret = 1'b0; ucall = 1'b1; j = 6'd10;
    cyc();
    j = 6'd30;
    cyc();
    j = 6'd50;
    cyc();
    chk("ovf_tgt", int'(u1), 50); chk("ovf_depth", int'(d1), 2);
    chk("ovf_flag", int'(o1), 1); chk("deep_depth", int'(d0), 3);
    ucall = 1'b0; uret = 1'b1;
    cyc(); chk("pop1", int'(u1), 11);
    cyc(); chk("pop2", int'(u1), 22);
    cyc(); chk("unf_addr", int'(u1), 18); chk("unf_flag", int'(n1), 1);
    chk("deep_pop3", int'(u0), 22);
    uret = 1'b0; j = 6'd5;
    cyc(); chk("ovf_sticky", int'(o1), 1); chk("unf_sticky", int'(n1), 1);

    // stall holds everything regardless of call/return/dispatch
    ucall = 1'b1; j = 6'd12;
    cyc(); chk("call12", int'(u0), 12);
    stall = 1'b1; j = 6'd40;
    cyc();
    ucall = 1'b0; uret = 1'b1;
    cyc();
    uret = 1'b0; ird = 1'b1; opcode = 4'h3;
    cyc(); chk("stall_uaddr", int'(u0), 12); chk("stall_depth", int'(d0), 1);
    stall = 1'b0; ird = 1'b0; ucall = 1'b1; uret = 1'b1;
    cyc(); chk("callret_pop", int'(u0), 6); chk("callret_depth", int'(d0), 0);

    // return address wraps from the last microaddress
    ucall = 1'b0; uret = 1'b0; j = 6'd63;
    cyc();
    ucall = 1'b1; j = 6'd1;
    cyc();
    ucall = 1'b0; uret = 1'b1;
    cyc(); chk("wrap_ret", int'(u0), 0);

    uret = 1'b0; rst = 1'b1;
    cyc(); chk("ovf_rst", int'(o1), 0); chk("unf_rst", int'(n1), 0);
    rst = 1'b0;

    // randomized traffic checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(63) == 0);
      stall  = ($urandom_range(7) == 0);
      ucall  = ($urandom_range(4) == 0);
      uret   = ($urandom_range(4) == 0);
      ird    = ($urandom_range(3) == 0);
      cond   = 3'($urandom_range(7));
      j      = 6'($urandom);
      qual   = 5'($urandom);
      opcode = 4'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
